// File: rtl/ddr_read_streamer_pkg.sv
// Shared DDR types plus the read-streamer state encoding, so the streamer
// and the arbiter bench agree on both.
package ddr_read_streamer_pkg;

    localparam int unsigned DDR_ADDR_W = 32;
    localparam int unsigned DDR_DATA_W = 32;

    typedef logic [DDR_ADDR_W-1:0] ddr_address_t;
    typedef logic [DDR_DATA_W-1:0] ddr_data_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHold,
        StDrain,
        StDone
    } ddr_rs_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push and a pop in the same
// cycle are accepted even when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = empty_o ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ddr_read_streamer.sv
// Issues sequential single-word DDR reads and streams the returned words
// downstream through a small FIFO; one transfer at a time.
module ddr_read_streamer
    import ddr_read_streamer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned ADDR_STRIDE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  ddr_address_t     base_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output ddr_address_t     ddr_address_o,
    output logic             ddr_r_en_o,
    input  ddr_data_t        ddr_r_data_i,
    input  logic             ddr_r_valid_i,
    output ddr_data_t        s_data_o,
    output logic             s_valid_o,
    input  logic             s_ready_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    ddr_rs_state_e    state_q;
    ddr_address_t     addr_q;
    logic [LEN_W-1:0] remaining_q;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    next_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    assign push          = (state_q == StReq) && ddr_r_valid_i;
    assign pop           = s_valid_o && s_ready_i;
    assign s_valid_o     = !fifo_empty;
    assign ddr_address_o = addr_q;
    // Occupancy after this edge, counting both a push and a pop.
    assign next_count    = fifo_count + CW'(push) - CW'(pop);

    sync_fifo #(
        .WIDTH (DDR_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (ddr_r_data_i),
        .pop_i       (pop),
        .pop_data_o  (s_data_o),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            ddr_r_en_o  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            addr_q      <= base_addr_i;
                            remaining_q <= len_i;
                            ddr_r_en_o  <= 1'b1;
                            state_q     <= StReq;
                        end else begin
                            done_o  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StReq: begin
                    if (ddr_r_valid_i) begin
                        addr_q      <= addr_q + ddr_address_t'(ADDR_STRIDE);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            ddr_r_en_o <= 1'b0;
                            state_q    <= StDrain;
                        end else if (next_count >= CW'(FIFO_DEPTH)) begin
                            ddr_r_en_o <= 1'b0;
                            state_q    <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (next_count < CW'(FIFO_DEPTH)) begin
                        ddr_r_en_o <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StDrain: begin
                    if (next_count == '0) begin
                        done_o  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_read_streamer.sv
// Directed bench: a small arbiter model answers each request two cycles
// later, and a scoreboard checks request addresses and streamed words.
module tb_ddr_read_streamer;
    import ddr_read_streamer_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    ddr_address_t base_addr_i = '0;
    logic [15:0]  len_i = '0;
    logic         busy_o;
    logic         done_o;
    ddr_address_t ddr_address_o;
    logic         ddr_r_en_o;
    ddr_data_t    ddr_r_data_i = '0;
    logic         ddr_r_valid_i = 1'b0;
    ddr_data_t    s_data_o;
    logic         s_valid_o;
    logic         s_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    ddr_data_t    exp_q[$];
    ddr_address_t addr_q[$];
    ddr_address_t req_addr;
    bit           pending = 0;
    int           lat = 0;
    int           reads_done = 0;
    int           done_cnt = 0;
    int           pop_at = -1;
    bit           sim_evt = 0;
    bit           ready_base = 0;
    bit           poke_start = 0;

    ddr_read_streamer #(
        .FIFO_DEPTH  (8),
        .LEN_W       (16),
        .ADDR_STRIDE (1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .len_i         (len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .ddr_address_o (ddr_address_o),
        .ddr_r_en_o    (ddr_r_en_o),
        .ddr_r_data_i  (ddr_r_data_i),
        .ddr_r_valid_i (ddr_r_valid_i),
        .s_data_o      (s_data_o),
        .s_valid_o     (s_valid_o),
        .s_ready_i     (s_ready_i)
    );

    always #5 clk = ~clk;

    function automatic ddr_data_t word_of(ddr_address_t a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: arbiter model, ready policy and output scoreboard at negedge.
    task automatic step();
        bit fire;
        fire = 0;
        @(negedge clk);
        start_i = poke_start;
        poke_start = 0;
        if (ddr_r_valid_i) begin
            ddr_r_valid_i = 1'b0;
            pending = 0;
        end
        if (pending) begin
            if (lat == 0) begin
                ddr_r_valid_i = 1'b1;
                ddr_r_data_i  = word_of(req_addr);
                if (reads_done == pop_at) begin
                    fire = 1;
                    sim_evt = 1;
                    pop_at = -1;
                end
                reads_done++;
            end else begin
                lat--;
            end
        end else if (ddr_r_en_o) begin
            chk("req_expected", 64'(addr_q.size() > 0), 64'(1));
            if (addr_q.size() > 0) chk("req_addr", 64'(ddr_address_o), 64'(addr_q.pop_front()));
            req_addr = ddr_address_o;
            pending = 1;
            lat = 1;
        end
        s_ready_i = ready_base | fire;
        if (done_o) done_cnt++;
        if (s_valid_o && s_ready_i) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word observed %0h expected none", s_data_o);
            end
            if (exp_q.size() != 0) chk("word", 64'(s_data_o), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic start_xfer(ddr_address_t b, logic [15:0] l);
        @(negedge clk);
        start_i = 1'b1;
        base_addr_i = b;
        len_i = l;
        for (int i = 0; i < int'(l); i++) begin
            addr_q.push_back(b + ddr_address_t'(i));
            exp_q.push_back(word_of(b + ddr_address_t'(i)));
        end
        reads_done = 0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_until_done(int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk("done_within_budget", 64'(done_cnt != 0), 64'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        // Reset state
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_ren", 64'(ddr_r_en_o), 64'(0));
        chk("rst_addr", 64'(ddr_address_o), 64'(0));
        chk("rst_svalid", 64'(s_valid_o), 64'(0));
        chk("rst_sdata", 64'(s_data_o), 64'(0));

        // Basic transfer
        ready_base = 1;
        start_xfer(32'h100, 16'd4);
        chk("basic_first_ren", 64'(ddr_r_en_o), 64'(1));
        chk("basic_first_addr", 64'(ddr_address_o), 64'(32'h100));
        chk("basic_busy", 64'(busy_o), 64'(1));
        run_until_done(60);
        step();
        chk("basic_busy_after", 64'(busy_o), 64'(0));
        repeat (3) step();
        chk("basic_reads", 64'(reads_done), 64'(4));
        chk("basic_done_pulses", 64'(done_cnt), 64'(1));
        chk("basic_words_left", 64'(exp_q.size()), 64'(0));

        // Backpressure into HOLD, then release
        ready_base = 0;
        start_xfer(32'h2000, 16'd12);
        repeat (40) step();
        chk("bp_reads_before_hold", 64'(reads_done), 64'(8));
        chk("bp_ren_hold", 64'(ddr_r_en_o), 64'(0));
        chk("bp_state_hold", 64'(dut.state_q), 64'(StHold));
        ready_base = 1;
        run_until_done(100);
        step();
        chk("bp_reads", 64'(reads_done), 64'(12));
        chk("bp_words_left", 64'(exp_q.size()), 64'(0));
        chk("bp_busy_after", 64'(busy_o), 64'(0));

        // Push and pop together at occupancy 7
        ready_base = 0;
        pop_at = 7;
        sim_evt = 0;
        start_xfer(32'h400, 16'd10);
        for (int n = 0; n < 100 && !sim_evt; n++) step();
        chk("full_evt_seen", 64'(sim_evt), 64'(1));
        @(posedge clk);
        #1;
        chk("full_occupancy", 64'(dut.fifo_count), 64'(7));
        chk("full_ren", 64'(ddr_r_en_o), 64'(1));
        ready_base = 1;
        run_until_done(100);
        step();
        chk("full_words_left", 64'(exp_q.size()), 64'(0));

        // Zero length
        start_xfer(32'h55, 16'd0);
        chk("zero_done", 64'(done_o), 64'(1));
        chk("zero_busy", 64'(busy_o), 64'(1));
        chk("zero_ren", 64'(ddr_r_en_o), 64'(0));
        @(posedge clk);
        #1;
        chk("zero_done_after", 64'(done_o), 64'(0));
        chk("zero_busy_after", 64'(busy_o), 64'(0));
        chk("zero_ren_after", 64'(ddr_r_en_o), 64'(0));

        // Address wrap
        start_xfer(32'hFFFF_FFFF, 16'd3);
        run_until_done(60);
        step();
        chk("wrap_reads", 64'(reads_done), 64'(3));
        chk("wrap_addrs_left", 64'(addr_q.size()), 64'(0));
        chk("wrap_words_left", 64'(exp_q.size()), 64'(0));

        // Reset mid-transfer, then a stray completion
        ready_base = 0;
        start_xfer(32'h800, 16'd6);
        for (int n = 0; n < 60 && reads_done < 2; n++) step();
        step();
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_svalid", 64'(s_valid_o), 64'(0));
        chk("mid_rst_ren", 64'(ddr_r_en_o), 64'(0));
        chk("mid_rst_busy", 64'(busy_o), 64'(0));
        chk("mid_rst_state", 64'(dut.state_q), 64'(StIdle));
        @(negedge clk);
        rst_i = 1'b0;
        exp_q.delete();
        addr_q.delete();
        ready_base = 1;
        repeat (6) step();
        chk("stray_svalid", 64'(s_valid_o), 64'(0));
        chk("stray_count", 64'(dut.fifo_count), 64'(0));

        // Start while busy is ignored
        start_xfer(32'h200, 16'd3);
        step();
        step();
        base_addr_i = 32'h900;
        len_i = 16'd5;
        poke_start = 1;
        run_until_done(60);
        repeat (10) step();
        chk("busy_start_reads", 64'(reads_done), 64'(3));
        chk("busy_start_done", 64'(done_cnt), 64'(1));
        chk("busy_start_ren", 64'(ddr_r_en_o), 64'(0));
        chk("busy_start_words_left", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
